// File: rtl/varwidth_capture_ctrl.sv
// Packs samples into buffer words, flushes the write pipeline, then drains sub-words over valid/ready.
// Latency: arm->capture 1 cycle, last sample->out_valid 5 cycles; out_valid holds under backpressure.
module varwidth_capture_ctrl #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WR_PER_ADDR = 3,
  parameter int RD_PER_ADDR = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  arm,
  input  logic                  abort,
  input  logic [ADDR_WIDTH:0]   capture_len,
  input  logic                  sample_valid,
  output logic                  mem_wr_ce,
  output logic [4:0]            mem_wr_ws,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic                  mem_rd_ce,
  output logic [4:0]            mem_rd_ws,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   words_captured
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CAPTURE = 3'd1,
    S_FLUSH   = 3'd2,
    S_FETCH   = 3'd3,
    S_SEND    = 3'd4
  } state_t;

  localparam logic [4:0]          WR_LAST = 5'(WR_PER_ADDR - 1);
  localparam logic [4:0]          RD_LAST = 5'(RD_PER_ADDR - 1);
  localparam logic [ADDR_WIDTH:0] DEPTH   = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] ONE_W   = (ADDR_WIDTH+1)'(1);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH:0]   len_q, len_d;
  logic [ADDR_WIDTH:0]   wc_q, wc_d;
  logic [4:0]            wr_ws_q, wr_ws_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [4:0]            rd_ws_q, rd_ws_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [1:0]            flush_q, flush_d;
  logic                  done_q, done_d;

  logic [ADDR_WIDTH:0]   wc_inc;
  logic [ADDR_WIDTH:0]   rd_addr_inc;

  assign wc_inc      = wc_q + ONE_W;
  assign rd_addr_inc = {1'b0, rd_addr_q} + ONE_W;

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    wc_d      = wc_q;
    wr_ws_d   = wr_ws_q;
    wr_addr_d = wr_addr_q;
    rd_ws_d   = rd_ws_q;
    rd_addr_d = rd_addr_q;
    flush_d   = flush_q;
    done_d    = 1'b0;

    if (abort) begin
      // words_captured survives an abort so the host can still see how far it got
      state_d   = S_IDLE;
      wr_ws_d   = '0;
      wr_addr_d = '0;
      rd_ws_d   = '0;
      rd_addr_d = '0;
      flush_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (arm) begin
            len_d     = capture_len;
            wc_d      = '0;
            wr_ws_d   = '0;
            wr_addr_d = '0;
            rd_ws_d   = '0;
            rd_addr_d = '0;
            flush_d   = '0;
            state_d   = (capture_len == '0) ? S_FLUSH : S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          if (sample_valid) begin
            if (wr_ws_q == WR_LAST) begin
              wr_ws_d   = '0;
              wr_addr_d = wr_addr_q + ADDR_WIDTH'(1);
              wc_d      = wc_inc;
              if ((wc_inc == len_q) || (wc_inc == DEPTH)) begin
                state_d = S_FLUSH;
                flush_d = '0;
              end
            end else begin
              wr_ws_d = wr_ws_q + 5'd1;
            end
          end
        end
        S_FLUSH: begin
          // three cycles cover the buffer's registered done/enable/clken stages
          if (flush_q == 2'd2) begin
            flush_d = '0;
            if (wc_q != '0) begin
              state_d = S_FETCH;
            end else begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end
          end else begin
            flush_d = flush_q + 2'd1;
          end
        end
        S_FETCH: begin
          state_d = S_SEND;
        end
        S_SEND: begin
          if (out_ready) begin
            if (rd_ws_q < RD_LAST) begin
              rd_ws_d = rd_ws_q + 5'd1;
            end else begin
              rd_ws_d = '0;
              if (rd_addr_inc < wc_q) begin
                rd_addr_d = rd_addr_q + ADDR_WIDTH'(1);
                state_d   = S_FETCH;
              end else begin
                state_d = S_IDLE;
                done_d  = 1'b1;
              end
            end
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      wc_q      <= '0;
      wr_ws_q   <= '0;
      wr_addr_q <= '0;
      rd_ws_q   <= '0;
      rd_addr_q <= '0;
      flush_q   <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      wc_q      <= wc_d;
      wr_ws_q   <= wr_ws_d;
      wr_addr_q <= wr_addr_d;
      rd_ws_q   <= rd_ws_d;
      rd_addr_q <= rd_addr_d;
      flush_q   <= flush_d;
      done_q    <= done_d;
    end
  end

  // read output register holds outside FETCH, so SEND can stall freely
  assign mem_wr_ce      = (state_q == S_CAPTURE) & sample_valid;
  assign mem_rd_ce      = (state_q == S_FETCH);
  assign out_valid      = (state_q == S_SEND);
  assign out_last       = out_valid & (rd_ws_q == RD_LAST) & ({1'b0, rd_addr_q} == (wc_q - ONE_W));
  assign busy           = (state_q != S_IDLE);
  assign done           = done_q;
  assign mem_wr_ws      = wr_ws_q;
  assign mem_wr_addr    = wr_addr_q;
  assign mem_rd_ws      = rd_ws_q;
  assign mem_rd_addr    = rd_addr_q;
  assign words_captured = wc_q;

endmodule

// File: tb/tb_varwidth_capture_ctrl.sv
// Bench for varwidth_capture_ctrl at an 8-word depth: write indices are scored per sample,
// drained sub-words are scored against a queue filled when the capture completes.
module tb_varwidth_capture_ctrl;

  typedef struct packed {
    logic [2:0] addr;
    logic [4:0] ws;
    logic       last;
  } sb_t;

  typedef struct packed {
    logic [2:0] addr;
    logic [4:0] ws;
  } wr_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       arm, abort, sample_valid, out_ready;
  logic [3:0] capture_len;
  logic       mem_wr_ce, mem_rd_ce, out_valid, out_last, busy, done;
  logic [4:0] mem_wr_ws, mem_rd_ws;
  logic [2:0] mem_wr_addr, mem_rd_addr;
  logic [3:0] words_captured;

  int checks   = 0;
  int failures = 0;
  sb_t exp_q[$];
  wr_t wr_q[$];

  varwidth_capture_ctrl #(.ADDR_WIDTH(3), .WR_PER_ADDR(3), .RD_PER_ADDR(4)) dut (
    .clk(clk), .reset_n(reset_n), .arm(arm), .abort(abort), .capture_len(capture_len),
    .sample_valid(sample_valid), .mem_wr_ce(mem_wr_ce), .mem_wr_ws(mem_wr_ws),
    .mem_wr_addr(mem_wr_addr), .mem_rd_ce(mem_rd_ce), .mem_rd_ws(mem_rd_ws),
    .mem_rd_addr(mem_rd_addr), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .done(done), .words_captured(words_captured)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; arm = 0; abort = 0; sample_valid = 0; out_ready = 0; capture_len = '0;
    repeat (3) step();
    #1;
    checks++;
    if ({out_valid, out_last, busy, done, mem_wr_ce, mem_rd_ce, mem_wr_ws, mem_wr_addr,
         mem_rd_ws, mem_rd_addr, words_captured} !== '0)
      begin failures++; $display("FAIL reset_outputs: got nonzero outputs busy=%b ov=%b wc=%0d", busy, out_valid, words_captured); end
    step(); reset_n = 1'b1;
    step(); sample_valid = 1; #1;
    checks++;
    if (mem_wr_ce !== 1'b0) begin failures++; $display("FAIL idle_wr_ce: got %b want 0", mem_wr_ce); end
    sample_valid = 0;
  endtask

  task automatic do_capture(input int len, input int nsamp, input int max_gap);
    int lim, m_ws, m_addr, m_wc, gap;
    wr_t w;
    lim = (len > 8) ? 8 : len;
    m_ws = 0; m_addr = 0; m_wc = 0;
    sample_valid = 0;
    step(); arm = 1; capture_len = 4'(len);
    step(); arm = 0;
    #1;
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL arm_busy: got %b want 1", busy); end
    for (int i = 0; i < nsamp && m_wc < lim; i++) begin
      gap = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
      for (int g = 0; g < gap; g++) begin
        sample_valid = 0; #1;
        checks++;
        if (mem_wr_ce !== 1'b0) begin failures++; $display("FAIL gap_wr_ce: got %b want 0", mem_wr_ce); end
        step();
      end
      sample_valid = 1;
      wr_q.push_back('{addr: 3'(m_addr), ws: 5'(m_ws)});
      #1;
      w = wr_q.pop_front();
      checks++;
      if (mem_wr_ce !== 1'b1 || mem_wr_ws !== w.ws || mem_wr_addr !== w.addr)
        begin failures++; $display("FAIL wr_index: got ce=%b ws=%0d addr=%0d want ce=1 ws=%0d addr=%0d", mem_wr_ce, mem_wr_ws, mem_wr_addr, w.ws, w.addr); end
      if (m_ws == 2) begin m_ws = 0; m_addr++; m_wc++; end
      else m_ws++;
      step();
    end
    // keep streaming: samples past the end of capture must be ignored
    sample_valid = 1;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (mem_wr_ce !== 1'b0 || out_valid !== 1'b0 || mem_rd_ce !== 1'b0 || busy !== 1'b1 || words_captured !== 4'(lim))
        begin failures++; $display("FAIL flush_cycle%0d: got wr_ce=%b ov=%b rd_ce=%b busy=%b wc=%0d want 0 0 0 1 %0d", c, mem_wr_ce, out_valid, mem_rd_ce, busy, words_captured, lim); end
      step();
    end
    #1;
    checks++;
    if (mem_rd_ce !== 1'b1 || out_valid !== 1'b0)
      begin failures++; $display("FAIL fetch_cycle: got rd_ce=%b ov=%b want 1 0", mem_rd_ce, out_valid); end
    for (int a = 0; a < lim; a++)
      for (int s = 0; s < 4; s++)
        exp_q.push_back('{addr: 3'(a), ws: 5'(s), last: (a == lim - 1) && (s == 3)});
    step();
    sample_valid = 0;
  endtask

  task automatic do_drain(input int mode, input int stop_after);
    int  hs = 0, cyc = 0, first = -1, words;
    bit  prev_stall = 0, tog = 0;
    sb_t e;
    words = exp_q.size() / 4;
    while (exp_q.size() > 0 && cyc < 400) begin
      case (mode)
        0:       out_ready = 1;
        1:       begin out_ready = tog; tog = ~tog; end
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      #1;
      if (prev_stall) begin
        checks++;
        if (out_valid !== 1'b1) begin failures++; $display("FAIL valid_hold: got %b want 1", out_valid); end
      end
      if (out_valid === 1'b1) begin
        if (first < 0) first = cyc;
        e = exp_q[0];
        checks++;
        if ({mem_rd_addr, mem_rd_ws, out_last, mem_rd_ce} !== {e.addr, e.ws, e.last, 1'b0})
          begin failures++; $display("FAIL drain_word: got addr=%0d ws=%0d last=%b rd_ce=%b want addr=%0d ws=%0d last=%b rd_ce=0", mem_rd_addr, mem_rd_ws, out_last, mem_rd_ce, e.addr, e.ws, e.last); end
        if (out_ready) begin void'(exp_q.pop_front()); hs++; prev_stall = 0; end
        else prev_stall = 1;
      end else begin
        prev_stall = 0;
      end
      if (exp_q.size() == 0 || (stop_after > 0 && hs == stop_after)) break;
      step(); cyc++;
    end
    if (stop_after > 0 && hs == stop_after) return;
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL drain_timeout: got %0d sub-words left want 0", exp_q.size());
      exp_q.delete();
      return;
    end
    if (mode == 0) begin
      checks++;
      if (cyc - first != 5 * words - 2) begin failures++; $display("FAIL drain_rate: got %0d cycles want %0d", cyc - first, 5 * words - 2); end
    end
    step(); out_ready = 0; #1;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL done_pulse: got done=%b busy=%b want 1 0", done, busy); end
    step(); #1;
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL done_width: got %b want 0", done); end
  endtask

  task automatic test_basic();
    do_capture(2, 6, 0);
    do_drain(0, 0);
    checks++;
    if (words_captured !== 4'd2) begin failures++; $display("FAIL basic_wc: got %0d want 2", words_captured); end
  endtask

  task automatic test_gapped();
    do_capture(3, 9, 3);
    do_drain(2, 0);
  endtask

  task automatic test_full_depth();
    do_capture(15, 30, 0);
    do_drain(0, 0);
  endtask

  task automatic test_backpressure();
    do_capture(2, 6, 0);
    do_drain(1, 0);
  endtask

  task automatic test_abort();
    step(); arm = 1; capture_len = 4'd2;
    step(); arm = 0;
    for (int i = 0; i < 4; i++) begin sample_valid = 1; step(); end
    sample_valid = 0; arm = 1; capture_len = 4'd5;
    step(); arm = 0; #1;
    checks++;
    if (mem_wr_ws !== 5'd1 || mem_wr_addr !== 3'd1 || busy !== 1'b1)
      begin failures++; $display("FAIL arm_ignored: got ws=%0d addr=%0d busy=%b want 1 1 1", mem_wr_ws, mem_wr_addr, busy); end
    abort = 1;
    step(); abort = 0; #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || mem_wr_ws !== 5'd0 || mem_wr_addr !== 3'd0 || words_captured !== 4'd1)
      begin failures++; $display("FAIL abort_capture: got busy=%b done=%b ws=%0d addr=%0d wc=%0d want 0 0 0 0 1", busy, done, mem_wr_ws, mem_wr_addr, words_captured); end
    arm = 1; abort = 1; capture_len = 4'd2;
    step(); arm = 0; abort = 0; #1;
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL arm_abort_same: got busy=%b want 0", busy); end
    do_capture(2, 6, 0);
    do_drain(0, 3);
    step(); abort = 1; out_ready = 0;
    step(); abort = 0; #1;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0 || mem_rd_ws !== 5'd0 || mem_rd_addr !== 3'd0 || words_captured !== 4'd2)
      begin failures++; $display("FAIL abort_send: got busy=%b ov=%b done=%b rws=%0d raddr=%0d wc=%0d want 0 0 0 0 0 2", busy, out_valid, done, mem_rd_ws, mem_rd_addr, words_captured); end
    exp_q.delete();
    do_capture(2, 6, 0);
    do_drain(0, 0);
  endtask

  task automatic test_zero_len();
    bit saw_ce = 0;
    step(); arm = 1; capture_len = 4'd0;
    step(); arm = 0;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (mem_rd_ce === 1'b1) saw_ce = 1;
      checks++;
      if (done !== (c == 3)) begin failures++; $display("FAIL zero_done_c%0d: got %b want %b", c, done, c == 3); end
      step();
    end
    checks++;
    if (saw_ce || words_captured !== 4'd0)
      begin failures++; $display("FAIL zero_len: got rd_ce_seen=%b wc=%0d want 0 0", saw_ce, words_captured); end
  endtask

  task automatic test_reset_mid();
    do_capture(2, 6, 0);
    do_drain(0, 3);
    step(); out_ready = 0; #1;
    checks++;
    if (out_valid !== 1'b1) begin failures++; $display("FAIL pre_reset_send: got %b want 1", out_valid); end
    reset_n = 1'b0; #1;
    checks++;
    if ({out_valid, out_last, busy, done, mem_wr_ce, mem_rd_ce, mem_wr_ws, mem_wr_addr,
         mem_rd_ws, mem_rd_addr, words_captured} !== '0)
      begin failures++; $display("FAIL reset_mid: got ov=%b busy=%b rws=%0d wc=%0d want all 0", out_valid, busy, mem_rd_ws, words_captured); end
    exp_q.delete();
    step(); reset_n = 1'b1;
    do_capture(2, 6, 0);
    do_drain(0, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_gapped();
    test_full_depth();
    test_backpressure();
    test_abort();
    test_zero_len();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
